lsu: RTL

Load/store unit for the single-cycle NPC core. Consumes the decoder's memory controls (`mem_ren`, `mem_wen`, `rmask`, `wmask`), the ALU-computed address, and the store data. Runs the matching transaction on an AXI-lite-style data bus: byte-lane alignment, load sign/zero extension, misalignment and bus-error detection, and a watchdog timeout. The core stalls from request acceptance until the one-cycle response.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the NPC load/store unit.
// Load kinds, store masks, FSM states and AXI response codes.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_W,
        S_B,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] LOAD_B  = 3'd0;
    localparam logic [2:0] LOAD_H  = 3'd1;
    localparam logic [2:0] LOAD_W  = 3'd2;
    localparam logic [2:0] LOAD_BU = 3'd4;
    localparam logic [2:0] LOAD_HU = 3'd5;

    localparam logic [3:0] W_BYTE = 4'h1;
    localparam logic [3:0] W_HALF = 4'h3;
    localparam logic [3:0] W_WORD = 4'hF;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == 2'd1) && lo[0]) || ((sz == 2'd2) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store shift/strobes, load extract/extend,
// and request legality (misalignment, conflicting or unknown codes).
import lsu_pkg::*;

module lsu_align (
    input  logic [1:0]  i_addr_lo,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [2:0]  i_rmask,
    input  logic [7:0]  i_wmask,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_off,
    input  logic [2:0]  i_ld_kind,
    input  logic [31:0] i_rd_raw,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic [31:0] o_ld_data,
    output logic        o_req_err
);

    logic [31:0] w_ld_sh;
    logic [1:0]  w_ld_sz;
    logic [1:0]  w_st_sz;
    logic        w_ld_ok;
    logic        w_st_ok;
    logic        w_unused;

    assign w_unused  = ^i_wmask[7:4];
    assign o_st_data = i_wdata << {i_addr_lo, 3'b000};
    assign o_st_strb = i_wmask[3:0] << i_addr_lo;
    assign w_ld_sh   = i_rd_raw >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = 32'h0;
        case (i_ld_kind)
            LOAD_B:  o_ld_data = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
            LOAD_H:  o_ld_data = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
            LOAD_W:  o_ld_data = w_ld_sh;
            LOAD_BU: o_ld_data = {24'h0, w_ld_sh[7:0]};
            LOAD_HU: o_ld_data = {16'h0, w_ld_sh[15:0]};
            default: o_ld_data = 32'h0;
        endcase
    end

    always_comb begin
        w_ld_sz = 2'd0;
        w_ld_ok = 1'b1;
        case (i_rmask)
            LOAD_B, LOAD_BU: w_ld_sz = 2'd0;
            LOAD_H, LOAD_HU: w_ld_sz = 2'd1;
            LOAD_W:          w_ld_sz = 2'd2;
            default:         w_ld_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_st_sz = 2'd0;
        w_st_ok = 1'b1;
        case (i_wmask[3:0])
            W_BYTE:  w_st_sz = 2'd0;
            W_HALF:  w_st_sz = 2'd1;
            W_WORD:  w_st_sz = 2'd2;
            default: w_st_ok = 1'b0;
        endcase
    end

    assign o_req_err = (i_ren & i_wen)
        | (i_ren & ~i_wen & (~w_ld_ok | misaligned(w_ld_sz, i_addr_lo)))
        | (i_wen & ~i_ren & (~w_st_ok | misaligned(w_st_sz, i_addr_lo)));

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory instruction at a time over an AXI-lite data
// bus, with a watchdog that aborts any stalled bus wait state.
import lsu_pkg::*;

module lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  rmask,
    input  logic [7:0]  wmask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        bus_arvalid,
    input  logic        bus_arready,
    output logic [31:0] bus_araddr,
    input  logic        bus_rvalid,
    output logic        bus_rready,
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  bus_rresp,
    output logic        bus_awvalid,
    input  logic        bus_awready,
    output logic [31:0] bus_awaddr,
    output logic        bus_wvalid,
    input  logic        bus_wready,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_bvalid,
    output logic        bus_bready,
    input  logic [1:0]  bus_bresp
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t  r_state;
    logic        r_req_ready, r_resp_valid, r_resp_err;
    logic [31:0] r_rdata, r_baddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic        r_aw_done, r_w_done;
    logic [1:0]  r_off;
    logic [2:0]  r_rmask;
    logic [CW-1:0] r_wdog;

    logic [31:0] w_st_data, w_ld_data;
    logic [3:0]  w_st_strb;
    logic        w_req_err, w_aw_ok, w_w_ok, w_wait, w_prog, w_to;

    lsu_align u_align (
        .i_addr_lo (addr[1:0]),
        .i_ren     (mem_ren),
        .i_wen     (mem_wen),
        .i_rmask   (rmask),
        .i_wmask   (wmask),
        .i_wdata   (wdata),
        .i_ld_off  (r_off),
        .i_ld_kind (r_rmask),
        .i_rd_raw  (bus_rdata),
        .o_st_data (w_st_data),
        .o_st_strb (w_st_strb),
        .o_ld_data (w_ld_data),
        .o_req_err (w_req_err)
    );

    assign w_aw_ok = r_aw_done | (r_awvalid & bus_awready);
    assign w_w_ok  = r_w_done | (r_wvalid & bus_wready);
    assign w_wait  = (r_state == S_AR) || (r_state == S_R)
                  || (r_state == S_W) || (r_state == S_B);
    assign w_prog  = ((r_state == S_AR) && bus_arready)
                  || ((r_state == S_R) && bus_rvalid)
                  || ((r_state == S_W) && w_aw_ok && w_w_ok)
                  || ((r_state == S_B) && bus_bvalid);
    assign w_to    = r_wdog >= CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= 32'h0;
            r_baddr      <= 32'h0;
            r_wdata      <= 32'h0;
            r_wstrb      <= 4'h0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_off        <= 2'b00;
            r_rmask      <= 3'd0;
            r_wdog       <= '0;
        end else begin
            if (w_wait)
                r_wdog <= r_wdog + 1'b1;
            // A stalled wait state aborts; any later bus response is ignored.
            if (w_wait && w_to && !w_prog) begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
                r_rdata      <= 32'h0;
                r_arvalid    <= 1'b0;
                r_rready     <= 1'b0;
                r_awvalid    <= 1'b0;
                r_wvalid     <= 1'b0;
                r_bready     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_off       <= addr[1:0];
                        r_rmask     <= rmask;
                        r_wdog      <= '0;
                        if (w_req_err || (!mem_ren && !mem_wen)) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_req_err;
                            r_rdata      <= 32'h0;
                        end else if (mem_ren) begin
                            r_state   <= S_AR;
                            r_arvalid <= 1'b1;
                            r_baddr   <= {addr[31:2], 2'b00};
                        end else begin
                            r_state   <= S_W;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_baddr   <= {addr[31:2], 2'b00};
                            r_wdata   <= w_st_data;
                            r_wstrb   <= w_st_strb;
                        end
                    end
                    S_AR: if (bus_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                    S_R: if (bus_rvalid) begin
                        r_rready     <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= bus_rresp != RESP_OKAY;
                        r_rdata      <= (bus_rresp != RESP_OKAY) ? 32'h0 : w_ld_data;
                    end
                    S_W: begin
                        if (r_awvalid && bus_awready) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (r_wvalid && bus_wready) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_aw_ok && w_w_ok) begin
                            r_bready <= 1'b1;
                            r_state  <= S_B;
                        end
                    end
                    S_B: if (bus_bvalid) begin
                        r_bready     <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= bus_bresp != RESP_OKAY;
                        r_rdata      <= 32'h0;
                    end
                    S_RESP: begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_rdata      <= 32'h0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign rdata       = r_rdata;
    assign bus_arvalid = r_arvalid;
    assign bus_araddr  = r_baddr;
    assign bus_rready  = r_rready;
    assign bus_awvalid = r_awvalid;
    assign bus_awaddr  = r_baddr;
    assign bus_wvalid  = r_wvalid;
    assign bus_wdata   = r_wdata;
    assign bus_wstrb   = r_wstrb;
    assign bus_bready  = r_bready;

endmodule
